// File: rtl/johnson_ring_counter_if.sv
// Control/status bundle for johnson_ring_counter: step controls in, state and decode out.
interface johnson_ring_counter_if #(
    parameter int WIDTH = 4,
    localparam int PW   = $clog2(2 * WIDTH)
);
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [PW-1:0]    phase;
    logic             tc;
    logic             err;

    modport master (
        output en, dir, load, load_val,
        input  q, phase, tc, err
    );

    modport slave (
        input  en, dir, load, load_val,
        output q, phase, tc, err
    );
endinterface

// File: rtl/johnson_ring_counter.sv
// Parametrised Johnson / one-hot ring counter with phase decode and terminal-count pulse.
// Optional illegal-state recovery and err flag enabled by `define JOHNSON_RING_SELF_CORRECT_EN.
module johnson_ring_counter #(
    parameter int  WIDTH = 4,
    parameter int  MODE  = 0,
    localparam int PW    = $clog2(2 * WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    johnson_ring_counter_if.slave   bus
);
    localparam int               NSTATES = (MODE == 1) ? WIDTH : 2 * WIDTH;
    localparam int               LAST    = NSTATES - 1;
    localparam logic [WIDTH-1:0] RST_VAL = (MODE == 1) ? WIDTH'(1) : '0;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] step;
    logic [PW-1:0]    phase;
    logic             legal;

    function automatic logic [WIDTH-1:0] lsb_ones(input int k);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = (i < k);
        return r;
    endfunction

    // Decode: legal states map to their position in the up sequence, anything else reads as 0.
    always_comb begin
        legal = 1'b0;
        phase = '0;
        if (MODE == 0) begin
            for (int k = 0; k <= WIDTH; k++) begin
                if (q_r == lsb_ones(k)) begin
                    legal = 1'b1;
                    phase = PW'(k);
                end
            end
            for (int j = 1; j < WIDTH; j++) begin
                if (q_r == ~lsb_ones(j)) begin
                    legal = 1'b1;
                    phase = PW'(WIDTH + j);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (q_r == (WIDTH'(1) << i)) begin
                    legal = 1'b1;
                    phase = PW'(i);
                end
            end
        end
    end

    always_comb begin
        step = q_r;
        if (MODE == 0)
            step = bus.dir ? {~q_r[0], q_r[WIDTH-1:1]} : {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
        else
            step = bus.dir ? {q_r[0], q_r[WIDTH-1:1]} : {q_r[WIDTH-2:0], q_r[WIDTH-1]};
    end

    always_ff @(posedge clk) begin
        if (reset)
            q_r <= RST_VAL;
        else if (bus.load)
            q_r <= bus.load_val;
`ifdef JOHNSON_RING_SELF_CORRECT_EN
        else if (!legal)
            q_r <= RST_VAL;
`endif
        else if (bus.en)
            q_r <= step;
    end

    assign bus.q     = q_r;
    assign bus.phase = phase;
    assign bus.tc    = bus.en & ~bus.load & legal &
                       ((~bus.dir & (phase == PW'(LAST))) | (bus.dir & (phase == '0)));

`ifdef JOHNSON_RING_SELF_CORRECT_EN
    assign bus.err = ~legal;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_johnson_ring_counter.sv
// Bench for johnson_ring_counter: WIDTH=4 Johnson and ring instances, directed plan plus random vs model.
module tb_johnson_ring_counter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m0, m1;

    always #5 clk = ~clk;

    johnson_ring_counter_if #(.WIDTH(W)) if0 ();
    johnson_ring_counter_if #(.WIDTH(W)) if1 ();

    johnson_ring_counter #(.WIDTH(W), .MODE(0)) dut0 (.clk(clk), .reset(rst0), .bus(if0.slave));
    johnson_ring_counter #(.WIDTH(W), .MODE(1)) dut1 (.clk(clk), .reset(rst1), .bus(if1.slave));

    // Reference model: states listed in up-sequence order, stepping is an index move around the cycle.
    function automatic int n_states(input int mode);
        return mode ? W : 2 * W;
    endfunction

    function automatic int seq_val(input int mode, input int idx);
        int mask = (1 << W) - 1;
        if (mode) return 1 << idx;
        if (idx <= W) return (1 << idx) - 1;
        return mask & ~((1 << (idx - W)) - 1);
    endfunction

    function automatic int find_idx(input int q, input int mode);
        for (int i = 0; i < n_states(mode); i++)
            if (seq_val(mode, i) == q) return i;
        return -1;
    endfunction

    function automatic int mdl_next(input int q, input int mode, input bit rs, input bit ld,
                                    input int lv, input bit en, input bit dir);
        int mask = (1 << W) - 1;
        int idx  = find_idx(q, mode);
        int msb  = (q >> (W - 1)) & 1;
        int lsb  = q & 1;
        if (rs) return mode ? 1 : 0;
        if (ld) return lv & mask;
`ifdef JOHNSON_RING_SELF_CORRECT_EN
        if (idx < 0) return mode ? 1 : 0;
`endif
        if (!en) return q;
        if (idx >= 0) return seq_val(mode, (idx + (dir ? n_states(mode) - 1 : 1)) % n_states(mode));
        // Illegal states under the raw shift rule (parasitic cycles).
        if (mode == 0) return dir ? ((q >> 1) | ((1 - lsb) << (W - 1))) : (((q * 2) & mask) | (1 - msb));
        return dir ? ((q >> 1) | (lsb << (W - 1))) : (((q * 2) & mask) | msb);
    endfunction

    function automatic bit mdl_tc(input int q, input int mode, input bit en, input bit ld, input bit dir);
        int idx = find_idx(q, mode);
        return en && !ld && idx >= 0 && (dir ? idx == 0 : idx == n_states(mode) - 1);
    endfunction

    function automatic bit mdl_err(input int q, input int mode);
`ifdef JOHNSON_RING_SELF_CORRECT_EN
        return find_idx(q, mode) < 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst0 = 0; rst1 = 0;
        if0.en = 0; if0.dir = 0; if0.load = 0; if0.load_val = '0;
        if1.en = 0; if1.dir = 0; if1.load = 0; if1.load_val = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        if0.load = 1; if0.load_val = 4'h9; if0.en = 1;
        rst0 = 1; rst1 = 1;
        clk_step();
        idle_inputs();
        #1;
        n_checks++;
        if (if0.q !== 4'h0 || if0.phase !== 3'd0 || if0.tc !== 1'b0 || if0.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_j: q=%h phase=%0d tc=%b err=%b want q=0 phase=0 tc=0 err=0",
                     if0.q, if0.phase, if0.tc, if0.err);
        end
        n_checks++;
        if (if1.q !== 4'h1 || if1.phase !== 3'd0 || if1.tc !== 1'b0 || if1.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_r: q=%h phase=%0d tc=%b err=%b want q=1 phase=0 tc=0 err=0",
                     if1.q, if1.phase, if1.tc, if1.err);
        end
    endtask

    task automatic test_johnson_up();
        logic [3:0] exp_q [9] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};
        logic [3:0] cur;
        rst0 = 1; clk_step(); idle_inputs();
        if0.en = 1; if0.dir = 0;
        for (int i = 0; i < 9; i++) begin
            cur = (i == 0) ? 4'h0 : exp_q[i-1];
            #1;
            n_checks++;
            if (if0.tc !== (cur == 4'h8)) begin
                n_fail++;
                $display("FAIL j_up_tc[%0d]: tc=%b want %b", i, if0.tc, (cur == 4'h8));
            end
            clk_step();
            n_checks++;
            if (if0.q !== exp_q[i] || if0.phase !== 3'((i + 1) % 8)) begin
                n_fail++;
                $display("FAIL j_up[%0d]: q=%h phase=%0d want q=%h phase=%0d",
                         i, if0.q, if0.phase, exp_q[i], (i + 1) % 8);
            end
        end
        idle_inputs();
    endtask

    task automatic test_johnson_down();
        logic [3:0] exp_q [8] = '{4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
        logic [3:0] cur;
        rst0 = 1; clk_step(); idle_inputs();
        if0.en = 1; if0.dir = 1;
        for (int i = 0; i < 8; i++) begin
            cur = (i == 0) ? 4'h0 : exp_q[i-1];
            #1;
            n_checks++;
            if (if0.tc !== (cur == 4'h0)) begin
                n_fail++;
                $display("FAIL j_dn_tc[%0d]: tc=%b want %b", i, if0.tc, (cur == 4'h0));
            end
            clk_step();
            n_checks++;
            if (if0.q !== exp_q[i]) begin
                n_fail++;
                $display("FAIL j_dn[%0d]: q=%h want %h", i, if0.q, exp_q[i]);
            end
        end
        // Reverse direction at F: the very next edge must go up to E.
        rst0 = 1; if0.en = 0; clk_step(); rst0 = 0;
        if0.en = 1; if0.dir = 1;
        repeat (4) clk_step();
        if0.dir = 0;
        clk_step();
        n_checks++;
        if (if0.q !== 4'hE) begin
            n_fail++;
            $display("FAIL j_dir_flip: q=%h want e", if0.q);
        end
        idle_inputs();
    endtask

    task automatic test_ring();
        logic       en_seq [3] = '{1'b1, 1'b0, 1'b1};
        logic [3:0] exp_q  [3] = '{4'h2, 4'h2, 4'h4};
        rst1 = 1; clk_step(); idle_inputs();
        for (int i = 0; i < 3; i++) begin
            if1.en = en_seq[i];
            #1;
            n_checks++;
            if (if1.tc !== 1'b0) begin
                n_fail++;
                $display("FAIL ring_tc[%0d]: tc=%b want 0", i, if1.tc);
            end
            clk_step();
            n_checks++;
            if (if1.q !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ring_up[%0d]: q=%h want %h", i, if1.q, exp_q[i]);
            end
        end
        rst1 = 1; clk_step(); idle_inputs();
        if1.en = 1; if1.dir = 1;
        #1;
        n_checks++;
        if (if1.tc !== 1'b1) begin
            n_fail++;
            $display("FAIL ring_dn_tc: tc=%b want 1", if1.tc);
        end
        clk_step();
        n_checks++;
        if (if1.q !== 4'h8 || if1.phase !== 3'd3) begin
            n_fail++;
            $display("FAIL ring_dn: q=%h phase=%0d want q=8 phase=3", if1.q, if1.phase);
        end
        idle_inputs();
    endtask

    task automatic test_load();
        if0.en = 1; if0.load = 1; if0.load_val = 4'h7;
        #1;
        n_checks++;
        if (if0.tc !== 1'b0) begin
            n_fail++;
            $display("FAIL load_tc: tc=%b want 0", if0.tc);
        end
        clk_step();
        n_checks++;
        if (if0.q !== 4'h7 || if0.phase !== 3'd3) begin
            n_fail++;
            $display("FAIL load: q=%h phase=%0d want q=7 phase=3", if0.q, if0.phase);
        end
        rst0 = 1; if0.load_val = 4'hF;
        clk_step();
        n_checks++;
        if (if0.q !== 4'h0) begin
            n_fail++;
            $display("FAIL load_vs_reset: q=%h want 0", if0.q);
        end
        idle_inputs();
    endtask

    task automatic test_illegal();
`ifdef JOHNSON_RING_SELF_CORRECT_EN
        if0.load = 1; if0.load_val = 4'h5;
        if1.load = 1; if1.load_val = 4'h3;
        clk_step();
        idle_inputs();
        #1;
        n_checks++;
        if (if0.q !== 4'h5 || if0.err !== 1'b1 || if0.phase !== 3'd0) begin
            n_fail++;
            $display("FAIL illegal_j: q=%h err=%b phase=%0d want q=5 err=1 phase=0",
                     if0.q, if0.err, if0.phase);
        end
        clk_step();
        n_checks++;
        if (if0.q !== 4'h0 || if0.err !== 1'b0) begin
            n_fail++;
            $display("FAIL recover_j: q=%h err=%b want q=0 err=0", if0.q, if0.err);
        end
        n_checks++;
        if (if1.q !== 4'h1 || if1.err !== 1'b0) begin
            n_fail++;
            $display("FAIL recover_r: q=%h err=%b want q=1 err=0", if1.q, if1.err);
        end
`else
        logic [3:0] exp_q [8] = '{4'h5, 4'hB, 4'h6, 4'hD, 4'hA, 4'h4, 4'h9, 4'h2};
        if0.load = 1; if0.load_val = 4'h2;
        clk_step();
        idle_inputs();
        if0.en = 1;
        for (int i = 0; i < 8; i++) begin
            clk_step();
            n_checks++;
            if (if0.q !== exp_q[i] || if0.err !== 1'b0) begin
                n_fail++;
                $display("FAIL parasitic[%0d]: q=%h err=%b want q=%h err=0", i, if0.q, if0.err, exp_q[i]);
            end
        end
`endif
        idle_inputs();
    endtask

    task automatic test_random();
        bit rs0, rs1, tc0, tc1;
        for (int c = 0; c < 400; c++) begin
            rs0 = (c == 0) || ($urandom_range(0, 31) == 0);
            rs1 = (c == 0) || ($urandom_range(0, 31) == 0);
            rst0 = rs0; rst1 = rs1;
            if0.load = ($urandom_range(0, 7) == 0); if0.load_val = 4'($urandom);
            if0.en = ($urandom_range(0, 3) != 0);   if0.dir = ($urandom_range(0, 3) == 0);
            if1.load = ($urandom_range(0, 7) == 0); if1.load_val = 4'($urandom);
            if1.en = ($urandom_range(0, 3) != 0);   if1.dir = ($urandom_range(0, 3) == 0);
            #1;
            if (c > 0) begin
                tc0 = mdl_tc(m0, 0, if0.en, if0.load, if0.dir);
                tc1 = mdl_tc(m1, 1, if1.en, if1.load, if1.dir);
                n_checks++;
                if (if0.tc !== tc0 || if1.tc !== tc1) begin
                    n_fail++;
                    $display("FAIL rnd_tc[%0d]: tc0=%b tc1=%b want %b %b", c, if0.tc, if1.tc, tc0, tc1);
                end
            end
            m0 = mdl_next(m0, 0, rs0, if0.load, int'(if0.load_val), if0.en, if0.dir);
            m1 = mdl_next(m1, 1, rs1, if1.load, int'(if1.load_val), if1.en, if1.dir);
            clk_step();
            n_checks++;
            if (if0.q !== 4'(m0) || if0.phase !== 3'(find_idx(m0, 0) < 0 ? 0 : find_idx(m0, 0)) ||
                if0.err !== mdl_err(m0, 0)) begin
                n_fail++;
                $display("FAIL rnd_j[%0d]: q=%h phase=%0d err=%b want q=%h", c, if0.q, if0.phase, if0.err, m0);
            end
            n_checks++;
            if (if1.q !== 4'(m1) || if1.phase !== 3'(find_idx(m1, 1) < 0 ? 0 : find_idx(m1, 1)) ||
                if1.err !== mdl_err(m1, 1)) begin
                n_fail++;
                $display("FAIL rnd_r[%0d]: q=%h phase=%0d err=%b want q=%h", c, if1.q, if1.phase, if1.err, m1);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        m0 = 0; m1 = 1;
        clk_step();
        test_reset();
        test_johnson_up();
        test_johnson_down();
        test_ring();
        test_load();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
